mult_unit: RTL and testbench
============================

Name: mult_unit

Overview:
- Multi-cycle radix-2 shift-add multiplier for MULT/MULTU, with architectural HI/LO registers.
- Accepts a request from decode on start_multD and drives mult_active back to the hazard unit, which stalls F/D and flushes E while the multiply runs.
- Services MTHI/MTLO writes from writeback and supplies HI/LO to MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits; base BUSY length is WIDTH cycles.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- start_multD  in  1  multiply request from decode; single-cycle pulse (upstream guarantee)
- signedD  in  1  1 = MULT (two's complement), 0 = MULTU
- srcAD  in  WIDTH  multiplicand, sampled with start_multD
- srcBD  in  WIDTH  multiplier, sampled with start_multD
- hi_weW  in  1  MTHI write enable
- lo_weW  in  1  MTLO write enable
- wdataW  in  WIDTH  MTHI/MTLO data
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- mult_active  out  1  high while state != IDLE, to the hazard unit
- mult_done  out  1  one-cycle pulse in the FINISH cycle

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; hi=0, lo=0; internal accumulator, multiplicand, multiplier, counter and sign flag cleared; mult_active=0; mult_done=0. This applies mid-operation too; the in-flight result is discarded.
- States: IDLE, BUSY, FINISH.
- IDLE -> BUSY when start_multD=1 at the edge.
  - Latch magnitudes: if signedD, |srcAD| and |srcBD|; otherwise the raw operands.
  - neg = signedD & (srcAD[WIDTH-1] ^ srcBD[WIDTH-1]).
  - acc = 0; cnt = 0.
  - Magnitude of the most negative value (0x80000000) is 0x80000000, treated as unsigned WIDTH-bit.
- BUSY, each cycle:
  - If mplier[0], acc += mcand << cnt (2*WIDTH-bit add, no overflow possible).
  - mplier >>= 1; cnt++.
  - After WIDTH cycles (cnt == WIDTH-1 at the edge), go to FINISH.
- FINISH, one cycle: {hi,lo} <= neg ? -acc : acc (2*WIDTH-bit two's complement); mult_done=1; -> IDLE.
- Timing: start sampled at the end of cycle T.
  - mult_active is 1 in cycles T+1 .. T+WIDTH+1 (WIDTH+1 cycles) and 0 again at T+WIDTH+2.
  - New hi/lo are visible from cycle T+WIDTH+2.
- mult_active is combinational from the state register only. It has no path from start_multD; the hazard unit covers that cycle with start_multD itself.
- start_multD while state != IDLE is ignored; the operation in flight is unaffected.
- MTHI/MTLO:
  - hi_weW/lo_weW write hi/lo at the edge in any state. They are older instructions draining M/W.
  - In FINISH, the multiply result has priority over a same-cycle hi_weW/lo_weW; the older write is lost by program order.
  - A write during BUSY is therefore overwritten by FINISH.
- hi/lo outputs are registered; there is no bypass of wdataW.

Optional Feature:
- Macro MULT_EARLY_EXIT_EN.
- Defined: in BUSY, if the shifted multiplier is zero after the current step, go to FINISH immediately.
  - Minimum BUSY length is 1 cycle (multiplier 0 or 1).
  - BUSY length = index of the highest set bit of |srcBD| + 1.
  - Results are identical to the non-early-exit build.
- Undefined: BUSY is always exactly WIDTH cycles; latency is fixed at WIDTH+1 active cycles.

Test Plan:
- MULTU 3 x 5, no macro -> mult_active high exactly 33 cycles, mult_done pulses once, then hi=0x00000000, lo=0x0000000F.
- MULT 0xFFFFFFFE (-2) x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- Boundary operands:
  - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- Writes around a multiply of 7 x 9:
  - MTHI 0x1234 on BUSY cycle 5 -> hi=0x00000000, lo=0x0000003F after FINISH.
  - hi_weW in the FINISH cycle -> dropped.
  - MTLO 0xABCD one cycle after FINISH -> lo=0x0000ABCD.
- Reset and ignored start:
  - reset_n=0 on BUSY cycle 10 -> next cycle mult_active=0, hi=lo=0.
  - A later start 6 x 7 gives lo=0x2A.
  - start_multD pulsed mid-BUSY -> ignored, original result unchanged.
- With MULT_EARLY_EXIT_EN:
  - MULTU 0x12345678 x 1 -> 2 active cycles, lo=0x12345678, hi=0.
  - Multiplier 0x80000000 -> 33 active cycles.

Source files
------------

// File: rtl/mult_unit.sv
// Radix-2 shift-add MULT/MULTU unit with architectural HI/LO registers and MTHI/MTLO write port.
// Latency: WIDTH+1 active cycles from start (MULT_EARLY_EXIT_EN: highest set bit of |B| + 2); no backpressure, start ignored while busy.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_multD,
    input  logic             signedD,
    input  logic [WIDTH-1:0] srcAD,
    input  logic [WIDTH-1:0] srcBD,
    input  logic             hi_weW,
    input  logic             lo_weW,
    input  logic [WIDTH-1:0] wdataW,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_active,
    output logic             mult_done
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [WIDTH-1:0]     a_mag, b_mag, mplier_shift;
    logic [2*WIDTH-1:0]   addend, result;
    logic                 last_step;

    always_comb begin
        a_mag        = (signedD && srcAD[WIDTH-1]) ? -srcAD : srcAD;
        b_mag        = (signedD && srcBD[WIDTH-1]) ? -srcBD : srcBD;
        mplier_shift = mplier_q >> 1;
        addend       = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
        result       = neg_q ? -acc_q : acc_q;
`ifdef MULT_EARLY_EXIT_EN
        last_step    = (mplier_shift == '0);
`else
        last_step    = (cnt_q == CNT_W'(WIDTH-1));
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (hi_weW) hi_d = wdataW;
        if (lo_weW) lo_d = wdataW;
        case (state_q)
            IDLE: begin
                if (start_multD) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = signedD & (srcAD[WIDTH-1] ^ srcBD[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (mplier_q[0]) acc_d = acc_q + addend;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_step) state_d = FINISH;
            end
            FINISH: begin
                // Multiply result is younger than any draining MTHI/MTLO, so it wins.
                {hi_d, lo_d} = result;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign mult_active = (state_q != IDLE);
    assign mult_done   = (state_q == FINISH);
endmodule

// File: tb/tb_mult_unit.sv
// Bench for mult_unit: arithmetic product/latency model checked every cycle, plus directed literal checks.
module tb_mult_unit;
    logic        clk = 1'b0;
    logic        reset_n, start_multD, signedD, hi_weW, lo_weW;
    logic [31:0] srcAD, srcBD, wdataW, hi, lo;
    logic        mult_active, mult_done;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    int          m_left = 0;

    always #5 clk = ~clk;

    mult_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start_multD(start_multD), .signedD(signedD),
        .srcAD(srcAD), .srcBD(srcBD), .hi_weW(hi_weW), .lo_weW(lo_weW), .wdataW(wdataW),
        .hi(hi), .lo(lo), .mult_active(mult_active), .mult_done(mult_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] product(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = {{32{s & a[31]}}, a};
        eb = {{32{s & b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic int active_len(input logic s, input logic [31:0] b);
`ifdef MULT_EARLY_EXIT_EN
        logic [31:0] m;
        int          h;
        m = (s && b[31]) ? -b : b;
        h = 0;
        for (int i = 0; i < 32; i++) if (m[i]) h = i;
        return h + 2;
`else
        return (s | b[0]) ? 33 : 33;
`endif
    endfunction

    // Reference model: counts down active cycles, last one commits the product.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else if (m_left == 1) begin
            {m_hi, m_lo} <= m_res;
            m_left <= 0;
        end else begin
            if (hi_weW) m_hi <= wdataW;
            if (lo_weW) m_lo <= wdataW;
            if (m_left > 0) m_left <= m_left - 1;
            else if (start_multD) begin
                m_res  <= product(signedD, srcAD, srcBD);
                m_left <= active_len(signedD, srcBD);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_active", {63'b0, mult_active}, {63'b0, m_left != 0});
            check("model_done",   {63'b0, mult_done},   {63'b0, m_left == 1});
            check("model_hi",     {32'b0, hi},          {32'b0, m_hi});
            check("model_lo",     {32'b0, lo},          {32'b0, m_lo});
        end
    end

    task automatic mul(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input int mthi_at, input bit mthi_fin, input int start_at,
                       output int n, output int dones);
        @(negedge clk);
        signedD = s; srcAD = a; srcBD = b; start_multD = 1'b1;
        @(negedge clk);
        start_multD = 1'b0;
        n = 0; dones = 0;
        while (mult_active && n < 100) begin
            n++;
            if (mult_done) dones++;
            hi_weW = (n == mthi_at) || (mthi_fin && mult_done);
            wdataW = mult_done ? 32'h5555 : 32'h1234;
            start_multD = (n == start_at);
            if (n == start_at) begin srcAD = 32'd100; srcBD = 32'd100; end
            @(negedge clk);
        end
        hi_weW = 1'b0; start_multD = 1'b0;
        check("mul_timeout", {63'b0, n >= 100}, 64'd0);
    endtask

    int n, d;

    initial begin
        reset_n = 1'b0; start_multD = 1'b0; signedD = 1'b0; hi_weW = 1'b0; lo_weW = 1'b0;
        srcAD = '0; srcBD = '0; wdataW = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", {32'b0, hi}, 64'd0);
        check("reset_lo", {32'b0, lo}, 64'd0);
        check("reset_active", {63'b0, mult_active}, 64'd0);
        check("reset_done", {63'b0, mult_done}, 64'd0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        mul(1'b0, 32'd3, 32'd5, -1, 1'b0, -1, n, d);
`ifdef MULT_EARLY_EXIT_EN
        check("3x5_cycles", n, 64'd4);
`else
        check("3x5_cycles", n, 64'd33);
`endif
        check("3x5_done_pulses", d, 64'd1);
        check("3x5", {hi, lo}, 64'h00000000_0000000F);

        mul(1'b1, 32'hFFFFFFFE, 32'd3, -1, 1'b0, -1, n, d);
        check("mult_m2x3", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        mul(1'b0, 32'hFFFFFFFE, 32'd3, -1, 1'b0, -1, n, d);
        check("multu_m2x3", {hi, lo}, 64'h00000002_FFFFFFFA);

        mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, -1, n, d);
        check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
        mul(1'b1, 32'h80000000, 32'h80000000, -1, 1'b0, -1, n, d);
        check("mult_minneg", {hi, lo}, 64'h40000000_00000000);
        check("minneg_cycles", n, 64'd33);

        mul(1'b0, 32'd7, 32'd9, 5, 1'b1, -1, n, d);
        check("7x9_writes_lost", {hi, lo}, 64'h00000000_0000003F);
        lo_weW = 1'b1; wdataW = 32'hABCD;
        @(negedge clk);
        lo_weW = 1'b0;
        check("mtlo_after", {hi, lo}, 64'h00000000_0000ABCD);

        @(negedge clk);
        signedD = 1'b0; srcAD = 32'h12345; srcBD = 32'hFFFF0000; start_multD = 1'b1;
        @(negedge clk);
        start_multD = 1'b0;
        repeat (9) @(negedge clk);
        check("busy10_active", {63'b0, mult_active}, 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midreset_active", {63'b0, mult_active}, 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);

        mul(1'b0, 32'd6, 32'd7, -1, 1'b0, -1, n, d);
        check("6x7", {hi, lo}, 64'h00000000_0000002A);

        mul(1'b0, 32'd11, 32'd13, -1, 1'b0, 2, n, d);
        check("ignored_start", {hi, lo}, 64'h00000000_0000008F);
        check("ignored_start_pulses", d, 64'd1);

        mul(1'b0, 32'h12345678, 32'd1, -1, 1'b0, -1, n, d);
        check("x1", {hi, lo}, 64'h00000000_12345678);
`ifdef MULT_EARLY_EXIT_EN
        check("x1_cycles", n, 64'd2);
`else
        check("x1_cycles", n, 64'd33);
`endif
        mul(1'b0, 32'h12345678, 32'h80000000, -1, 1'b0, -1, n, d);
        check("xmsb", {hi, lo}, 64'h091A2B3C_00000000);
        check("xmsb_cycles", n, 64'd33);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
